keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//  Synthesizable model of the 4x4 Pmod keypad: the responder end of the column-scan interface.
//  It takes "press key K" commands and answers the scanner's active-low column strobes with
//  active-low row levels, exactly as the physical switch matrix would.
//  Used for board loopback self-test (scanner kcol -> emulator col, emulator row -> scanner krow)
//  and as the stimulus model in keypad_decoder/SSD benches.
// PARAMETERS
//  HOLD_CYCLES    1_000_000  clocks the key stays pressed (10 ms at 100 MHz); must be >= 1
//  GAP_CYCLES     500_000    released clocks after a press before the next command is accepted; >= 1
//  BOUNCE_CYCLES  0          length of the contact-bounce window at press start (0 = clean press)
//  BOUNCE_PERIOD  1000       toggle period of the contact inside the bounce window; >= 1
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous, active-low reset
//  cmd_valid  in   1  press request
//  cmd_key    in   4  hex key to press (0x0-0xF)
//  cmd_ready  out  1  high when a command is accepted this cycle
//  abort      in   1  cancel the current press/gap
//  col        in   4  column strobes from the scanner, active-low, normally one-cold
//  row        out  4  row levels to the scanner, active-low, idle 4'hF
//  busy       out  1  press or gap in progress
//  done       out  1  one-cycle pulse when the gap completes
// BEHAVIOUR
//  Reset (async assert, sync release) forces:
//   state=IDLE; row=4'hF; cmd_ready=1; busy=0; done=0; counters=0; key register=0.
//  Key map (row r, col c), r/c = 0..3:
//   r0 = 1 2 3 A;  r1 = 4 5 6 B;  r2 = 7 8 9 C;  r3 = 0 F E D.
//  Row output:
//   - registered; row[r] = ~(contact & ~col[c]) for the held key's r/c, all other row bits = 1.
//   - latency is exactly 1 clk from a col change to the row change.
//   - if several cols are low, the key's row still asserts whenever its own col is low.
//  Handshake:
//   - accept when cmd_valid & cmd_ready; cmd_ready = (state==IDLE) & ~abort.
//   - a cmd_valid while busy is ignored, not queued.
//  FSM states: IDLE -> PRESS -> GAP -> IDLE.
//   IDLE:  on accept, latch cmd_key, clear counter, go to PRESS.
//   PRESS: contact=1 except inside the first BOUNCE_CYCLES clocks, where contact toggles every
//          BOUNCE_PERIOD clocks starting at 1. After HOLD_CYCLES clocks go to GAP
//          (HOLD_CYCLES includes the bounce window; BOUNCE_CYCLES >= HOLD_CYCLES means the
//          whole press bounces).
//   GAP:   contact=0. After GAP_CYCLES clocks go to IDLE and pulse done for 1 cycle.
//  busy = (state != IDLE). done can coincide with nothing else; a new command is accepted
//  at the earliest the cycle after done.
//  abort in PRESS/GAP: next state IDLE, contact=0, no done pulse. abort in IDLE blocks
//  acceptance that cycle.
//  abort & cmd_valid in the same IDLE cycle: abort wins.
//  Counters are $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1) bits, saturate at terminal count,
//  and never wrap.
//  cmd_key is latched at accept only; changes while busy have no effect.
// STRUCTURE
//  kpd_pkg (shared with keypad_decoder):
//   - typedef kpd_rc_t {logic [1:0] r, c;}
//   - function key_to_rc(logic [3:0]) implementing the key map
//   - typedef enum emu_state_t {IDLE, PRESS, GAP}
//   - localparam KPD_IDLE_ROW = 4'hF
//  One sub-module: kpd_contact_gen (counter + bounce toggle, outputs contact and terminal count).
//  Row drive stays in the top.
// TESTING
//  1 Reset: hold rst_n=0 mid-PRESS for key 5 -> row=F immediately; busy=0, cmd_ready=1 after release.
//  2 Key 0x6, HOLD=8, GAP=4, col cycling E,D,B,7 -> row=4'hD exactly 1 clk after col=B;
//    row=F on the other cols; done pulses at clock 12 after accept.
//  3 All 16 keys back-to-back through keypad_decoder -> decode_out equals each cmd_key.
//  4 BOUNCE_CYCLES=6, BOUNCE_PERIOD=2, col=E, key 1 -> row[0] pattern 0,0,1,1,0,0, then steady 0.
//  5 cmd_valid with key 9 during PRESS of key 2 -> ignored; only key 2 appears, cmd_ready=0 throughout.
//  6 abort at PRESS clock 3 -> row=F next cycle, no done, cmd_ready=1 the following cycle.

Source files
------------

// File: rtl/kpd_pkg.sv
// Shared definitions for the 4x4 Pmod keypad blocks.
// Covers the key-to-matrix map, the emulator state encoding and the idle row level.
package kpd_pkg;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] c;
    } kpd_rc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } emu_state_t;

    localparam logic [3:0] KPD_IDLE_ROW = 4'hF;

    // Physical layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D
    function automatic kpd_rc_t key_to_rc(input logic [3:0] key);
        kpd_rc_t rc;
        case (key)
            4'h1: rc = '{r: 2'd0, c: 2'd0};
            4'h2: rc = '{r: 2'd0, c: 2'd1};
            4'h3: rc = '{r: 2'd0, c: 2'd2};
            4'hA: rc = '{r: 2'd0, c: 2'd3};
            4'h4: rc = '{r: 2'd1, c: 2'd0};
            4'h5: rc = '{r: 2'd1, c: 2'd1};
            4'h6: rc = '{r: 2'd1, c: 2'd2};
            4'hB: rc = '{r: 2'd1, c: 2'd3};
            4'h7: rc = '{r: 2'd2, c: 2'd0};
            4'h8: rc = '{r: 2'd2, c: 2'd1};
            4'h9: rc = '{r: 2'd2, c: 2'd2};
            4'hC: rc = '{r: 2'd2, c: 2'd3};
            4'h0: rc = '{r: 2'd3, c: 2'd0};
            4'hF: rc = '{r: 2'd3, c: 2'd1};
            4'hE: rc = '{r: 2'd3, c: 2'd2};
            default: rc = '{r: 2'd3, c: 2'd3};
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/kpd_contact_gen.sv
// Press/gap duration counter with contact-bounce generation for the keypad emulator.
// Counter saturates at the terminal count of the current phase; clr_i restarts a phase.
module kpd_contact_gen #(
    parameter int unsigned HOLD_CYCLES   = 1_000_000,
    parameter int unsigned GAP_CYCLES    = 500_000,
    parameter int unsigned BOUNCE_CYCLES = 0,
    parameter int unsigned BOUNCE_PERIOD = 1000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic press_i,
    output logic contact_o,
    output logic tc_o
);

    localparam int unsigned CNT_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);
    localparam int unsigned PW       = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
    // A bounce window longer than the counter range never closes during the press
    localparam int unsigned BNC_LAST = (BOUNCE_CYCLES == 0)      ? 0 :
                                       (BOUNCE_CYCLES > CNT_MAX) ? CNT_MAX :
                                                                   BOUNCE_CYCLES - 1;

    localparam logic [CW-1:0] HOLD_TC    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_TC     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BNC_LAST_C = CW'(BNC_LAST);
    localparam logic [PW-1:0] PH_TC      = PW'(BOUNCE_PERIOD - 1);
    localparam logic          HAS_BOUNCE = (BOUNCE_CYCLES != 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic          tog_q, tog_d;
    logic          bwin_q, bwin_d;

    assign tc_o      = press_i ? (cnt_q == HOLD_TC) : (cnt_q == GAP_TC);
    assign contact_o = press_i & (bwin_q ? tog_q : 1'b1);

    always_comb begin
        cnt_d  = cnt_q;
        ph_d   = ph_q;
        tog_d  = tog_q;
        bwin_d = bwin_q;
        if (clr_i) begin
            cnt_d  = '0;
            ph_d   = '0;
            tog_d  = 1'b1;
            bwin_d = HAS_BOUNCE;
        end else if (en_i) begin
            if (!tc_o) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (cnt_q == BNC_LAST_C) begin
                bwin_d = 1'b0;
            end
            if (ph_q == PH_TC) begin
                ph_d  = '0;
                tog_d = ~tog_q;
            end else begin
                ph_d = ph_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            ph_q   <= '0;
            tog_q  <= 1'b1;
            bwin_q <= HAS_BOUNCE;
        end else begin
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            tog_q  <= tog_d;
            bwin_q <= bwin_d;
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Responder side of the 4x4 Pmod keypad column scan: presses one commanded key at a time
// and answers active-low column strobes with registered active-low row levels.
module keypad_emulator
    import kpd_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 1_000_000,
    parameter int unsigned GAP_CYCLES    = 500_000,
    parameter int unsigned BOUNCE_CYCLES = 0,
    parameter int unsigned BOUNCE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_key,
    output logic       cmd_ready,
    input  logic       abort,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       busy,
    output logic       done
);

    emu_state_t state_q, state_d;
    logic [3:0] key_q, key_d;
    logic [3:0] row_q, row_d;
    logic       cnt_clr, cnt_en;
    logic       contact, tc;
    kpd_rc_t    rc;

    kpd_contact_gen #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES),
        .BOUNCE_CYCLES(BOUNCE_CYCLES),
        .BOUNCE_PERIOD(BOUNCE_PERIOD)
    ) u_contact (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .press_i  (state_q == PRESS),
        .contact_o(contact),
        .tc_o     (tc)
    );

    assign cmd_ready = (state_q == IDLE) & ~abort;
    assign busy      = (state_q != IDLE);
    assign row       = row_q;
    assign rc        = key_to_rc(key_q);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    key_d   = cmd_key;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (tc) begin
                    cnt_clr = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (tc) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Abort drops the contact in the same cycle so the row releases on the next edge
    always_comb begin
        row_d = KPD_IDLE_ROW;
        if (contact && !abort && !col[rc.c]) begin
            row_d[rc.r] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            row_q   <= KPD_IDLE_ROW;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against a clean and a bouncing instance.
module tb_keypad_emulator;

    localparam int HOLD = 8;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_valid_b = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cmd_key = 4'h0;
    logic [3:0] col = 4'hF;
    logic       cmd_ready, busy, done;
    logic       cmd_ready_b, busy_b, done_b;
    logic [3:0] row, row_b;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES(8), .GAP_CYCLES(4), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_key(cmd_key),
        .cmd_ready(cmd_ready), .abort(abort), .col(col), .row(row),
        .busy(busy), .done(done)
    );

    keypad_emulator #(
        .HOLD_CYCLES(8), .GAP_CYCLES(4), .BOUNCE_CYCLES(6), .BOUNCE_PERIOD(2)
    ) u_bnc (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_key(cmd_key),
        .cmd_ready(cmd_ready_b), .abort(abort), .col(col), .row(row_b),
        .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic       sel;
        logic [3:0] row;
        logic       busy;
        logic       ready;
        logic       done;
        string      name;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] colseq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    // Key map as printed on the keypad: returns {row, col}
    function automatic logic [3:0] tb_rc(input logic [3:0] k);
        case (k)
            4'h1: return {2'd0, 2'd0};
            4'h2: return {2'd0, 2'd1};
            4'h3: return {2'd0, 2'd2};
            4'hA: return {2'd0, 2'd3};
            4'h4: return {2'd1, 2'd0};
            4'h5: return {2'd1, 2'd1};
            4'h6: return {2'd1, 2'd2};
            4'hB: return {2'd1, 2'd3};
            4'h7: return {2'd2, 2'd0};
            4'h8: return {2'd2, 2'd1};
            4'h9: return {2'd2, 2'd2};
            4'hC: return {2'd2, 2'd3};
            4'h0: return {2'd3, 2'd0};
            4'hF: return {2'd3, 2'd1};
            4'hE: return {2'd3, 2'd2};
            default: return {2'd3, 2'd3};
        endcase
    endfunction

    function automatic void chk(input string nm, input string fld, input int cyc,
                                input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s cyc %0d: got %h expected %h", nm, fld, cyc, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.name, "row",       e.cyc, e.sel ? row_b : row,                      e.row);
            chk(e.name, "busy",      e.cyc, {3'b0, e.sel ? busy_b : busy},             {3'b0, e.busy});
            chk(e.name, "cmd_ready", e.cyc, {3'b0, e.sel ? cmd_ready_b : cmd_ready},   {3'b0, e.ready});
            chk(e.name, "done",      e.cyc, {3'b0, e.sel ? done_b : done},             {3'b0, e.done});
        end
    end

    task automatic step(input logic rn, input logic v, input logic vb, input logic [3:0] k,
                        input logic ab, input logic [3:0] c, input logic sel,
                        input logic [3:0] er, input logic eb, input logic erd, input logic ed,
                        input string nm, input int j);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n       = rn;
        cmd_valid   = v;
        cmd_valid_b = vb;
        cmd_key     = k;
        abort       = ab;
        col         = c;
        x.sel = sel; x.row = er; x.busy = eb; x.ready = erd; x.done = ed;
        x.name = nm; x.cyc = j;
        exp_q.push_back(x);
    endtask

    // One full command on the clean instance with cycling column strobes.
    // ab_at < 0 means no abort; spam keeps cmd_valid high with key 9 while busy.
    task automatic press_seq(input logic [3:0] key, input int ab_at, input logic spam,
                             input string nm);
        logic [3:0] rc, c, k, erow;
        logic       v, ab, ebusy, erdy, edone, contact_prev;
        logic [3:0] col_prev;
        int         last;
        rc = tb_rc(key);
        last = (ab_at >= 0) ? ab_at + 3 : HOLD + GAP;
        contact_prev = 1'b0;
        col_prev = 4'hF;
        for (int j = 0; j <= last; j++) begin
            c     = colseq[j % 4];
            ab    = (j == ab_at);
            ebusy = (j >= 1) && (j <= HOLD + GAP) && (ab_at < 0 || j <= ab_at);
            erdy  = !ebusy && !ab;
            edone = (j == HOLD + GAP) && (ab_at < 0);
            erow  = (contact_prev && !col_prev[rc[1:0]]) ? ~(4'b0001 << rc[3:2]) : 4'hF;
            v     = (j == 0) || (spam && j <= HOLD + GAP);
            k     = (j == 0) ? key : (spam ? 4'h9 : ~key);
            step(1'b1, v, 1'b0, k, ab, c, 1'b0, erow, ebusy, erdy, edone, nm, j);
            contact_prev = (j >= 1) && (j <= HOLD) && (ab_at < 0 || j < ab_at);
            col_prev = c;
        end
    endtask

    logic [3:0] bnc_row [13] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hE,
                                 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF};

    initial begin
        // Reset state
        for (int j = 0; j < 2; j++)
            step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "reset", j);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, "reset_b", 0);

        press_seq(4'h6, -1, 1'b0, "key6");

        for (int k = 0; k < 16; k++)
            press_seq(4'(k), -1, 1'b0, "all_keys");

        press_seq(4'h2, -1, 1'b1, "ignore_busy");
        press_seq(4'h5, 3, 1'b0, "abort_press");

        // Abort beats cmd_valid in IDLE; nothing is accepted later either
        step(1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 4'hE, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, "abort_idle", 0);
        step(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 4'hE, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "abort_idle", 1);
        step(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 4'hE, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "abort_idle", 2);

        // Bouncing instance, key 1 on column 0
        for (int j = 0; j <= HOLD + GAP; j++)
            step(1'b1, 1'b0, (j == 0), 4'h1, 1'b0, 4'hE, 1'b1, bnc_row[j],
                 (j >= 1), (j == 0), (j == HOLD + GAP), "bounce", j);

        // Reset asserted in the middle of a press of key 5
        step(1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 4'hD, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "reset_mid", 0);
        step(1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'hD, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, "reset_mid", 1);
        step(1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'hD, 1'b0, 4'hD, 1'b1, 1'b0, 1'b0, "reset_mid", 2);
        step(1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 4'hD, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "reset_mid", 3);
        step(1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 4'hD, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "reset_mid", 4);
        step(1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'hD, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "reset_mid", 5);
        step(1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'hD, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "reset_mid", 6);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
